// File: rtl/vga_pkg.sv
// vga_pkg: framebuffer geometry constants and owner tags shared by memory clients.
package vga_pkg;
   localparam int FB_ADDR_W = 15;
   localparam int FB_DATA_W = 3;
   typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_DISP = 2'd1, TAG_DRAW = 2'd2} tag_t;
endpackage

// File: rtl/fb_tag_pipe.sv
// fb_tag_pipe: delay line of owner tags so each read response can be routed to its requester.
module fb_tag_pipe
   import vga_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic clk,
   input  logic reset,
   input  tag_t tag_in,
   output tag_t tag_out
);
   tag_t pipe [DEPTH];
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) pipe[i] <= TAG_NONE;
      end else begin
         pipe[0] <= tag_in;
         for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
      end
   assign tag_out = pipe[DEPTH-1];
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one single-port framebuffer RAM; display reads have strict
// priority, draw ops fill idle cycles through a valid/ready handshake.
module fb_port_arbiter
   import vga_pkg::*;
#(
   parameter int ADDR_W  = FB_ADDR_W,
   parameter int DATA_W  = FB_DATA_W,
   parameter int MEM_LAT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   input  logic              draw_valid,
   output logic              draw_ready,
   input  logic              draw_we,
   input  logic [ADDR_W-1:0] draw_addr,
   input  logic [DATA_W-1:0] draw_wdata,
   output logic [DATA_W-1:0] draw_rdata,
   output logic              draw_rvalid,
   input  logic              freeze,
   input  logic              stat_clr,
   output logic [7:0]        stall_cnt,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);
   logic grant_draw;
   tag_t tag_in, tag_out;
   // draw_ready is also held low during reset so nothing is accepted then
   always_comb begin
      draw_ready = !reset && !disp_req && !freeze;
      grant_draw = draw_ready && draw_valid;
      tag_in     = disp_req ? TAG_DISP : (grant_draw && !draw_we) ? TAG_DRAW : TAG_NONE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
      end else begin
         mem_en    <= disp_req || grant_draw;
         mem_we    <= grant_draw && draw_we;
         mem_addr  <= disp_req ? disp_addr : draw_addr;
         mem_wdata <= grant_draw ? draw_wdata : mem_wdata;
      end
   // one stage for the mem_* register plus MEM_LAT stages of RAM latency
   fb_tag_pipe #(.DEPTH(MEM_LAT + 1)) u_tag_pipe (
      .clk     (clk),
      .reset   (reset),
      .tag_in  (tag_in),
      .tag_out (tag_out)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         disp_valid  <= 1'b0;
         disp_data   <= '0;
         draw_rvalid <= 1'b0;
         draw_rdata  <= '0;
      end else begin
         disp_valid  <= tag_out == TAG_DISP;
         draw_rvalid <= tag_out == TAG_DRAW;
         disp_data   <= tag_out == TAG_DISP ? mem_rdata : disp_data;
         draw_rdata  <= tag_out == TAG_DRAW ? mem_rdata : draw_rdata;
      end
   always_ff @(posedge clk or posedge reset)
      if (reset) stall_cnt <= '0;
      else if (stat_clr) stall_cnt <= '0;
      else if (draw_valid && !draw_ready && stall_cnt != 8'hFF) stall_cnt <= stall_cnt + 8'd1;
endmodule
